// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Bundles the signals of the UART receive buffer. This covers the byte-done
//   pulse from the receiver, the FWFT read port, and the status and overflow
//   reporting.
//   slave  : the FIFO side. It takes the receiver pulse, rd_ready and
//            clr_overflow. It drives the read port and the status outputs.
//   master : the surrounding logic. Its directions are the reverse of slave.
interface uart_rx_fifo_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                    uart_rx_valid;
    logic                    uart_rx_break;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    rd_ready;
    logic                    rd_valid;
    logic [PAYLOAD_BITS-1:0] rd_data;
    logic                    rd_break;
    logic [ADDR_W:0]         count;
    logic                    full;
    logic                    rx_level;
    logic                    overflow;
    logic [7:0]              drop_count;
    logic                    clr_overflow;

    modport slave (
        input  uart_rx_valid, uart_rx_break, uart_rx_data, rd_ready, clr_overflow,
        output rd_valid, rd_data, rd_break, count, full, rx_level, overflow, drop_count
    );

    modport master (
        output uart_rx_valid, uart_rx_break, uart_rx_data, rd_ready, clr_overflow,
        input  rd_valid, rd_data, rd_break, count, full, rx_level, overflow, drop_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Circular receive buffer that sits after the UART receiver. Each one-cycle
//   valid pulse stores {break, data} as one entry. The head entry is shown
//   first-word-fall-through on a valid/ready read port. If the buffer is full
//   and nothing pops, the incoming byte is dropped. A drop sets a sticky
//   overflow flag and bumps a saturating 8-bit drop counter.
// Ports
//   clk    : system clock
//   resetn : asynchronous active-low reset; discards all entries
//   bus    : uart_rx_fifo_if.slave. It carries the receiver pulse, the read
//            port, count/full/rx_level, and overflow/drop_count/clr_overflow.
module uart_rx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16,
    parameter int LEVEL        = 8
) (
    input  logic           clk,
    input  logic           resetn,
    uart_rx_fifo_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_LEVEL = (ADDR_W+1)'(LEVEL);

    logic [PAYLOAD_BITS:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic [7:0]            drop_count;

    logic push, pop, full, wr_en, drop;

    assign full  = (count == CNT_FULL);
    assign push  = bus.uart_rx_valid;
    assign pop   = (count != '0) & bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // Storage has no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {bus.uart_rx_break, bus.uart_rx_data};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
            if (wr_en && !pop)      count <= count + (ADDR_W+1)'(1);
            else if (pop && !wr_en) count <= count - (ADDR_W+1)'(1);
        end
    end

    // A drop in the same cycle as clr_overflow wins and restarts the tally at 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            if (bus.clr_overflow)        drop_count <= 8'd1;
            else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else if (bus.clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    assign {bus.rd_break, bus.rd_data} = mem[rd_ptr];
    assign bus.rd_valid   = (count != '0);
    assign bus.count      = count;
    assign bus.full       = full;
    assign bus.rx_level   = (count >= CNT_LEVEL);
    assign bus.overflow   = overflow;
    assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. The reference is a plain queue of
//   {break,data} entries plus an overflow bit and a drop tally. After every
//   clock it checks all DUT outputs against that reference. The stimulus is
//   a directed sequence followed by a randomized phase.
module tb_uart_rx_fifo;
    localparam int PB = 8;
    localparam int DEPTH = 16;
    localparam int LEVEL = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH), .LEVEL(LEVEL)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [PB:0] q[$];
    logic        m_ovf;
    int          m_dc;
    int          n_pass = 0;
    int          n_tot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(q.size() != 0));
        chk({tag, ".count"},    32'(bus.count),    32'(q.size()));
        chk({tag, ".full"},     32'(bus.full),     32'(q.size() == DEPTH));
        chk({tag, ".rx_level"}, 32'(bus.rx_level), 32'(q.size() >= LEVEL));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".drop_cnt"}, 32'(bus.drop_count), 32'(m_dc));
        if (q.size() != 0) begin
            chk({tag, ".rd_data"},  32'(bus.rd_data),  32'(q[0][PB-1:0]));
            chk({tag, ".rd_break"}, 32'(bus.rd_break), 32'(q[0][PB]));
        end
    endtask

    // One clock. Drive the inputs, advance the reference, then check the
    // outputs 1ns after the edge.
    task automatic step(input logic v, input logic brk, input logic [PB-1:0] d,
                        input logic rdy, input logic clr, input string tag);
        bit was_full, do_pop;
        bus.uart_rx_valid = v;
        bus.uart_rx_break = brk;
        bus.uart_rx_data  = d;
        bus.rd_ready      = rdy;
        bus.clr_overflow  = clr;
        was_full = (q.size() == DEPTH);
        do_pop   = rdy && (q.size() != 0);
        if (v && was_full && !do_pop) begin
            m_ovf = 1'b1;
            m_dc  = clr ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_dc  = 0;
        end
        if (do_pop) void'(q.pop_front());
        if (v && (!was_full || do_pop)) q.push_back({brk, d});
        @(posedge clk);
        #1;
        bus.uart_rx_valid = 1'b0;
        bus.rd_ready      = 1'b0;
        bus.clr_overflow  = 1'b0;
        check_all(tag);
    endtask

    task automatic push(input logic [PB-1:0] d, input string tag);
        step(1'b1, 1'b0, d, 1'b0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        while (q.size() != 0) step(1'b0, 1'b0, '0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_break = 1'b0;
        bus.uart_rx_data  = '0;
        bus.rd_ready      = 1'b0;
        bus.clr_overflow  = 1'b0;
        m_ovf = 1'b0;
        m_dc  = 0;

        // reset state
        #12;
        check_all("reset");
        resetn = 1'b1;
        #10;
        check_all("post_reset");

        // basic push/pop order
        push(8'h55, "t1");
        push(8'hA3, "t1");
        chk("t1.head55", 32'(bus.rd_data), 32'h55);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, "t1.pop");
        chk("t1.headA3", 32'(bus.rd_data), 32'hA3);
        chk("t1.count1", 32'(bus.count), 32'd1);
        drain("t1.drain");

        // fill, level threshold, overflow drop, ordered drain
        for (int i = 0; i < DEPTH; i++) push(PB'(i), "t2.fill");
        chk("t2.full", 32'(bus.full), 32'd1);
        push(8'hFF, "t2.drop");
        chk("t2.dc1", 32'(bus.drop_count), 32'd1);
        drain("t2.drain");

        // full + push + pop: both succeed, nothing dropped
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, "t3.clr");
        for (int i = 0; i < DEPTH; i++) push(PB'(8'h20 + i), "t3.fill");
        step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, "t3.pushpop");
        chk("t3.cnt16", 32'(bus.count), 32'd16);
        chk("t3.noovf", 32'(bus.overflow), 32'd0);
        drain("t3.drain");

        // break tag
        step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, "t4.brk");
        chk("t4.rd_break", 32'(bus.rd_break), 32'd1);
        push(8'h41, "t4.norm");
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, "t4.pop");
        chk("t4.rd_break0", 32'(bus.rd_break), 32'd0);
        drain("t4.drain");

        // drop counter saturation; clear loses to a simultaneous drop
        for (int i = 0; i < DEPTH; i++) push(PB'(i), "t5.fill");
        for (int i = 0; i < 300; i++) push(8'hEE, "t5.drop");
        chk("t5.sat", 32'(bus.drop_count), 32'd255);
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, "t5.clrdrop");
        chk("t5.dc1", 32'(bus.drop_count), 32'd1);
        chk("t5.ovf1", 32'(bus.overflow), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, "t5.clr");
        drain("t5.drain");

        // async reset mid-stream
        for (int i = 0; i < 5; i++) push(PB'(8'h90 + i), "t6.fill");
        resetn = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_dc  = 0;
        #1;
        chk("t6.rst_count", 32'(bus.count), 32'd0);
        chk("t6.rst_valid", 32'(bus.rd_valid), 32'd0);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        push(8'h3C, "t6.after");
        chk("t6.3C", 32'(bus.rd_data), 32'h3C);
        // wrap: one entry resident while pairs stream through
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, PB'($urandom), 1'b1, 1'b0, "t6.wrap");
        drain("t6.drain");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 9) == 0),
                 PB'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 29) == 0), "rand");
        end
        drain("rand.drain");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
